weight_loader: RTL and testbench

Fills the per-column weight FIFOs that feed the systolic array's weight inputs. Accepts one row-major stream of weight words over a valid/ready handshake and scatters each word to the FIFO of its column: word i goes to column i mod SYS_COLS. Sits between the host/DMA weight stream and the column FIFOs. It drives their write ports, which the column weight buffer leaves open.

---
 rtl/weight_loader.sv | 133 +++++++++++++
 tb/tb_weight_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// weight_loader
// Scatters a row-major stream of weight words into the per-column weight
// FIFOs of the systolic array. Word i of a load is written to column
// i mod SYS_COLS. A load is SYS_COLS*W_ROWS words long.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rstn        asynchronous active-low reset
//   start       one-cycle load request, honoured only in IDLE
//   abort       (only with WEIGHT_LOADER_ABORT_EN) drop the current load
//   s_valid     stream word valid
//   s_ready     stream word accepted when s_valid && s_ready
//   s_data      stream word
//   fifo_afull  per-column almost-full (<=1 free slot)
//   wr_en       per-column registered write strobe
//   wr_data     per-column registered write data, column c at [c*DWIDTH +: DWIDTH]
//   busy        high in LOAD and DONE
//   done        one-cycle pulse together with the final write
//
// Configuration macro: WEIGHT_LOADER_ABORT_EN adds the abort input.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start, stream not accepted
// LOAD  | accepting words, s_ready follows the current column's afull
// DONE  | final write and done pulse issued, returns to IDLE next cycle

module weight_loader #(
    parameter int SYS_COLS = 4,
    parameter int DWIDTH   = 8,
    parameter int W_ROWS   = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
`ifdef WEIGHT_LOADER_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DWIDTH-1:0]          s_data,
    input  logic [SYS_COLS-1:0]        fifo_afull,
    output logic [SYS_COLS-1:0]        wr_en,
    output logic [SYS_COLS*DWIDTH-1:0] wr_data,
    output logic                       busy,
    output logic                       done
);

    localparam int COL_W = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;
    localparam int ROW_W = (W_ROWS > 1) ? $clog2(W_ROWS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SYS_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(W_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              abort_i;
    logic              hs;

`ifdef WEIGHT_LOADER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Ready depends only on state, current column and its afull (plus abort),
    // never on s_valid.
    assign s_ready = (state == LOAD) && !fifo_afull[col] && !abort_i;
    assign hs      = s_valid && s_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            wr_en   <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            wr_en <= '0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state <= IDLE;
                        col   <= '0;
                        row   <= '0;
                    end else if (hs) begin
                        wr_en[col]                     <= 1'b1;
                        wr_data[col*DWIDTH +: DWIDTH]  <= s_data;
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (row == LAST_ROW) begin
                                row   <= '0;
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end
                default: begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Randomized scoreboard bench for weight_loader (SYS_COLS=4, W_ROWS=3).
// The driver models the load as a word counter n: word n belongs to column
// n mod C and is the last word when n == C*R-1. Expected writes are queued
// at handshake time and popped by an independent monitor.

module tb_weight_loader;

    localparam int C     = 4;
    localparam int DW    = 8;
    localparam int R     = 3;
    localparam int TOTAL = C * R;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [C-1:0]      fifo_afull;
    logic [C-1:0]      wr_en;
    logic [C*DW-1:0]   wr_data;
    logic              busy;
    logic              done;
`ifdef WEIGHT_LOADER_ABORT_EN
    logic              abort;
`endif

    always #5 clk = ~clk;

    weight_loader #(.SYS_COLS(C), .DWIDTH(DW), .W_ROWS(R)) dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef WEIGHT_LOADER_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .fifo_afull (fifo_afull),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int          col;
        logic [DW-1:0] data;
        bit          last;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] last_wd [C];
    int            checks   = 0;
    int            passes   = 0;
    int            done_cnt = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitor: samples 2 time units after each rising edge.
    initial begin : monitor
        exp_t e;
        logic [C-1:0] oh;
        forever begin
            @(posedge clk);
            #2;
            if (rstn) begin
                if (wr_en != '0) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_write", 64'(wr_en), 64'(0));
                    end else begin
                        e  = expq.pop_front();
                        oh = '0;
                        oh[e.col] = 1'b1;
                        chk("wr_en_onehot", 64'(wr_en), 64'(oh));
                        chk("wr_data", 64'(wr_data[e.col*DW +: DW]), 64'(e.data));
                        last_wd[e.col] = e.data;
                        for (int c = 0; c < C; c++)
                            if (c != e.col)
                                chk("wr_data_hold", 64'(wr_data[c*DW +: DW]), 64'(last_wd[c]));
                        chk("done_with_write", 64'(done), 64'(e.last));
                    end
                    if (done) done_cnt++;
                end else if (done) begin
                    chk("done_without_write", 64'(done), 64'(0));
                    done_cnt++;
                end
            end
        end
    end

    // afull_mode: 0 none, 1 hold column 2 almost-full for 5 cycles in row 0,
    // 2 random. stop_after: stop issuing words once that many were accepted.
    task automatic run_load(input int vprob, input int afull_mode, input int stop_after,
                            input bit data_seq, input bit start_in_done);
        int           n     = 0;
        int           cyc   = 0;
        int           stall = 0;
        int           d0    = done_cnt;
        logic [C-1:0] af;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        while (n < TOTAL && n != stop_after && cyc < 2000) begin
            cyc++;
            s_valid = ($urandom_range(99) < vprob);
            s_data  = data_seq ? DW'(n + 1) : DW'($urandom);
            af = '0;
            if (afull_mode == 1 && (n % C) == 2 && n < C && stall < 5) begin
                af[2] = 1'b1;
                stall++;
            end else if (afull_mode == 2) begin
                af = C'($urandom & $urandom);
            end
            fifo_afull = af;
            start = ($urandom_range(9) == 0);
            #1;
            chk("s_ready", 64'(s_ready), 64'(!af[n % C]));
            if (s_valid && s_ready) begin
                expq.push_back('{col: n % C, data: s_data, last: (n == TOTAL - 1)});
                n++;
            end
            @(negedge clk);
        end
        start      = 1'b0;
        s_valid    = 1'b0;
        fifo_afull = '0;
        if (cyc >= 2000) chk("load_timeout", 64'(n), 64'(TOTAL));
        if (n == TOTAL) begin
            start = start_in_done;
            chk("busy_in_done", 64'(busy), 64'(1));
            @(negedge clk);
            start = 1'b0;
            chk("busy_back_idle", 64'(busy), 64'(0));
            chk("done_pulses", 64'(done_cnt - d0), 64'(1));
        end
    endtask

    task automatic check_reset_values();
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_wr_en",   64'(wr_en),   64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_busy",    64'(busy),    64'(0));
        chk("rst_done",    64'(done),    64'(0));
    endtask

    initial begin
        int d0;
        rstn       = 1'b0;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        fifo_afull = '0;
`ifdef WEIGHT_LOADER_ABORT_EN
        abort      = 1'b0;
`endif
        for (int c = 0; c < C; c++) last_wd[c] = '0;
        #1;
        check_reset_values();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // 12 sequential words, start pulsed in DONE, then a new load straight after
        run_load(100, 0, -1, 1, 1);
        run_load(100, 1, -1, 1, 0);
        run_load(50, 0, -1, 0, 0);
        run_load(70, 2, -1, 0, 0);

        // reset after word 7
        run_load(100, 0, 7, 1, 0);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values();
        chk("queue_drained_before_reset", 64'(expq.size()), 64'(0));
        expq.delete();
        for (int c = 0; c < C; c++) last_wd[c] = '0;
        #1;
        rstn = 1'b1;
        @(negedge clk);
        run_load(100, 0, -1, 1, 0);

`ifdef WEIGHT_LOADER_ABORT_EN
        d0 = done_cnt;
        run_load(100, 0, 5, 1, 0);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        #1;
        chk("s_ready_abort", 64'(s_ready), 64'(0));
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("busy_after_abort", 64'(busy), 64'(0));
        chk("no_done_on_abort", 64'(done_cnt - d0), 64'(0));
        run_load(100, 0, -1, 1, 0);
`else
        d0 = done_cnt;
`endif
        run_load(60, 2, -1, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_empty_at_end", 64'(expq.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
